// File: rtl/gpio_input.sv
`default_nettype none
// ============================================================================
// Module   : gpio_input
// Purpose  : Conditions the board's slide switches and pushbuttons into one
//            32-bit word for the CPU. Switches are synchronized only; each
//            pushbutton is synchronized, debounced, and turned into a level,
//            a sticky press flag and a shared wrapping press counter.
// Ports    : clk      - system clock, all state changes on its rising edge
//            rst      - synchronous active-high reset
//            SW[17:0] - raw slide switches (asynchronous, 1 = up)
//            KEY[2:0] - raw pushbuttons KEY[3:1] (asynchronous, active-low)
//            ack      - CPU read-acknowledge, clears the sticky press flags
//            GPIO_in  - {press_count[7:0], press_flag[2:0], key_level[2:0],
//                        sw_sync[17:0]}
// Revision : 1.0 - initial release
// ============================================================================
module gpio_input #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [17:0] SW,
    input  logic [2:0]  KEY,
    input  logic        ack,
    output logic [31:0] GPIO_in
);

    localparam logic [19:0] c_CNT_LAST = 20'(DEBOUNCE_CYCLES - 1);

    // Encoding chosen so that bit 1 is the debounced key level directly.
    typedef enum logic [1:0] {
        IDLE_UP    = 2'b00,
        CHECK_DOWN = 2'b01,
        HELD_DOWN  = 2'b10,
        CHECK_UP   = 2'b11
    } state_t;

    logic [17:0] r_sw_meta;
    logic [17:0] r_sw_sync;
    logic [2:0]  r_key_meta;
    logic [2:0]  r_key_sync;
    logic [2:0]  r_flag;
    logic [7:0]  r_count;

    logic [2:0]  w_event;
    logic [2:0]  w_level;
    logic [1:0]  w_ev_count;

    // Two-flop synchronizers; keys are inverted first so 1 means pressed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sw_meta  <= '0;
            r_sw_sync  <= '0;
            r_key_meta <= '0;
            r_key_sync <= '0;
        end else begin
            r_sw_meta  <= SW;
            r_sw_sync  <= r_sw_meta;
            r_key_meta <= ~KEY;
            r_key_sync <= r_key_meta;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_key
            state_t      r_state;
            state_t      w_state_next;
            logic [19:0] r_cnt;
            logic [19:0] w_cnt_next;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= IDLE_UP;
                    r_cnt   <= '0;
                end else begin
                    r_state <= w_state_next;
                    r_cnt   <= w_cnt_next;
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                case (r_state)
                    IDLE_UP: begin
                        w_cnt_next = '0;
                        if (r_key_sync[g]) begin
                            w_state_next = CHECK_DOWN;
                            w_cnt_next   = 20'd1;
                        end
                    end
                    CHECK_DOWN: begin
                        if (!r_key_sync[g]) begin
                            w_state_next = IDLE_UP;
                            w_cnt_next   = '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            w_state_next = HELD_DOWN;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + 20'd1;
                        end
                    end
                    HELD_DOWN: begin
                        w_cnt_next = '0;
                        if (!r_key_sync[g]) begin
                            w_state_next = CHECK_UP;
                            w_cnt_next   = 20'd1;
                        end
                    end
                    CHECK_UP: begin
                        if (r_key_sync[g]) begin
                            w_state_next = HELD_DOWN;
                            w_cnt_next   = '0;
                        end else if (r_cnt == c_CNT_LAST) begin
                            w_state_next = IDLE_UP;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = r_cnt + 20'd1;
                        end
                    end
                    default: begin
                        w_state_next = IDLE_UP;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            // Only a confirmed press produces an event; releases are silent.
            assign w_event[g] = (r_state == CHECK_DOWN) && (w_state_next == HELD_DOWN);
            assign w_level[g] = r_state[1];
        end
    endgenerate

    assign w_ev_count = {1'b0, w_event[0]} + {1'b0, w_event[1]} + {1'b0, w_event[2]};

    // A press landing on the same edge as ack keeps its flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag  <= '0;
            r_count <= '0;
        end else begin
            r_flag  <= (ack ? 3'b000 : r_flag) | w_event;
            r_count <= r_count + {6'b0, w_ev_count};
        end
    end

    assign GPIO_in = {r_count, r_flag, w_level, r_sw_sync};

endmodule
`default_nettype wire

// File: tb/tb_gpio_input.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_input
// Purpose  : Directed scoreboard bench for gpio_input with DEBOUNCE_CYCLES=4.
//            Stimulus queues expected GPIO_in words tagged with the clock edge
//            after which they must hold; a monitor compares on falling edges.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_input;

    localparam int DEB = 4;
    localparam logic [31:0] S = 32'h0002A5A5;

    logic        clk;
    logic        rst;
    logic [17:0] SW;
    logic [2:0]  KEY;
    logic        ack;
    logic [31:0] GPIO_in;

    gpio_input #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk     (clk),
        .rst     (rst),
        .SW      (SW),
        .KEY     (KEY),
        .ack     (ack),
        .GPIO_in (GPIO_in)
    );

    typedef struct {
        int          tgt;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   edge_n   = 0;
    int   compared = 0;
    int   mismatched = 0;
    bit   done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n = edge_n + 1;

    // Monitor: the output is registered, so every falling edge presents a word.
    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].tgt == edge_n) begin
                compared = compared + 1;
                if (GPIO_in !== sb[i].exp) begin
                    mismatched = mismatched + 1;
                    $display("FAIL %s: GPIO_in=%h expected=%h (edge %0d)",
                             sb[i].name, GPIO_in, sb[i].exp, edge_n);
                end
                sb.delete(i);
            end else begin
                i = i + 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input int k, input logic [31:0] v, input string nm);
        sb.push_back('{tgt: edge_n + k, exp: v, name: nm});
    endtask

    task automatic press_release(input logic [2:0] mask);
        KEY = ~mask;
        tick(6);
        KEY = 3'b111;
        tick(6);
    endtask

    initial begin
        rst = 1'b1;
        SW  = '0;
        KEY = 3'b111;
        ack = 1'b0;
        tick(2);
        expect_at(1, 32'h0, "reset_state");
        tick(1);

        // Switch path: two-edge latency, no debounce.
        rst = 1'b0;
        SW  = 18'h2A5A5;
        expect_at(1, 32'h0, "sw_latency1");
        expect_at(2, S, "sw_sync");
        tick(4);

        // Clean press and release of KEY[1].
        KEY = 3'b110;
        expect_at(5, S, "key1_before_debounce");
        expect_at(6, 32'h0126A5A5, "key1_press");
        tick(8);
        KEY = 3'b111;
        expect_at(5, 32'h0126A5A5, "key1_release_pending");
        expect_at(6, 32'h0122A5A5, "key1_release");
        tick(8);

        // Bounce on KEY[2] shorter than the debounce window.
        KEY = 3'b101;
        tick(3);
        KEY = 3'b111;
        expect_at(2, 32'h0122A5A5, "bounce_mid");
        tick(2);
        KEY = 3'b101;
        tick(3);
        KEY = 3'b111;
        expect_at(3, 32'h0122A5A5, "bounce_after1");
        expect_at(8, 32'h0122A5A5, "bounce_after2");
        tick(10);

        // Build flags 011, then acknowledge.
        KEY = 3'b101;
        expect_at(6, 32'h026AA5A5, "key2_press");
        tick(8);
        KEY = 3'b111;
        expect_at(6, 32'h0262A5A5, "key2_release");
        tick(8);
        ack = 1'b1;
        expect_at(1, 32'h0202A5A5, "ack_clear");
        tick(1);
        ack = 1'b0;
        tick(2);

        // ack coinciding with a KEY[3] press event: the event wins.
        KEY = 3'b110;
        expect_at(6, 32'h0326A5A5, "key1_press2");
        tick(8);
        KEY = 3'b010;
        tick(5);
        ack = 1'b1;
        expect_at(1, 32'h0496A5A5, "ack_vs_event");
        tick(1);
        ack = 1'b0;
        KEY = 3'b111;
        expect_at(6, 32'h0482A5A5, "release_both");
        tick(8);

        // Preload count to 254, then a triple press wraps it to 1.
        for (int n = 0; n < 250; n++) press_release(3'b001);
        expect_at(1, 32'hFEA2A5A5, "count_254");
        tick(2);
        KEY = 3'b000;
        expect_at(5, 32'hFEA2A5A5, "triple_pending");
        expect_at(6, 32'h01FEA5A5, "count_wrap");
        tick(8);
        KEY = 3'b111;
        tick(8);

        // Reset in the middle of a KEY[1] debounce with count 5.
        for (int n = 0; n < 4; n++) press_release(3'b001);
        expect_at(1, 32'h05E2A5A5, "count_5");
        tick(2);
        KEY = 3'b110;
        tick(4);
        rst = 1'b1;
        expect_at(1, 32'h0, "reset_mid_debounce");
        tick(1);
        rst = 1'b0;
        expect_at(1, 32'h0, "post_reset_e1");
        expect_at(5, S, "post_reset_e5");
        expect_at(6, 32'h0126A5A5, "post_reset_press");
        tick(8);
        KEY = 3'b111;
        tick(10);

        // Anything still queued was never reached.
        while (sb.size() > 0) begin
            compared = compared + 1;
            mismatched = mismatched + 1;
            $display("FAIL %s: not checked (timeout) expected=%h", sb[0].name, sb[0].exp);
            void'(sb.pop_front());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        done = 1'b1;
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL global_timeout: simulation did not finish, compared=%0d", compared);
            $fatal(1);
        end
    end

endmodule
`default_nettype wire
